// File: rtl/spi_reg_controller.sv
// SPI mode-0 write-frame controller: serialises {write, addr[6:0], data[7:0]} MSB first.
// Optional readback capture of cipo is built when SPI_REG_CONTROLLER_READBACK_EN is defined.
module spi_reg_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI
`ifdef SPI_REG_CONTROLLER_READBACK_EN
  ,
  input  logic       cipo,
  output logic [7:0] rsp_rdata
`endif
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] SHIFT_LO = 3'd2;
  localparam logic [2:0] SHIFT_HI = 3'd3;
  localparam logic [2:0] HOLD     = 3'd4;
  localparam logic [2:0] GAP      = 3'd5;

  localparam int MAX_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_CD  = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_HALF  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(CS_HOLD - 1);
  // GAP also contains the done cycle, so CS_IDLE full cycles follow it.
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(CS_IDLE);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_cnt;
  // Bit 15 goes straight to COPI on accept, so only the remaining 15 bits are stored.
  logic [14:0]      shreg;

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      nCS     <= 1'b1;
      SCLK    <= 1'b0;
      COPI    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            shreg   <= {cmd_addr, cmd_data};
            COPI    <= cmd_write;
            nCS     <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
            cnt     <= LD_SETUP;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cnt   <= LD_HALF;
            state <= SHIFT_LO;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHIFT_LO: begin
          if (cnt == '0) begin
            SCLK  <= 1'b1;
            cnt   <= LD_HALF;
            state <= SHIFT_HI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHIFT_HI: begin
          if (cnt == '0) begin
            SCLK    <= 1'b0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              cnt   <= LD_HOLD;
              state <= HOLD;
            end else begin
              COPI  <= shreg[14];
              shreg <= {shreg[13:0], 1'b0};
              cnt   <= LD_HALF;
              state <= SHIFT_LO;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            nCS   <= 1'b1;
            done  <= 1'b1;
            COPI  <= 1'b0;
            cnt   <= LD_GAP;
            state <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          nCS   <= 1'b1;
          SCLK  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SPI_REG_CONTROLLER_READBACK_EN
  logic [7:0] rx_shift;

  // Data bits are frame positions 8..15, i.e. bit_cnt[3] set; sampled as SCLK rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift  <= '0;
      rsp_rdata <= '0;
    end else begin
      if (state == SHIFT_LO && cnt == '0 && bit_cnt[3])
        rx_shift <= {rx_shift[6:0], cipo};
      if (state == HOLD && cnt == '0)
        rsp_rdata <= rx_shift;
    end
  end
`endif

  a_sclk_idle_when_deselected: assert property (@(posedge clk) disable iff (!rst_n)
    nCS |-> !SCLK);
  a_ready_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    cmd_ready |-> !busy);

endmodule
